// File: rtl/scarv_cop_malu_dispatch_if.sv
// Bus between the MALU dispatcher and its environment.
// Carries the decode handshake, the CPR read and write ports, and the MALU
// issue/result signals. The slave modport is the dispatcher's view; the
// master modport is the surrounding decode/CPR/MALU view.
interface scarv_cop_malu_dispatch_if;
  // Decode side
  logic        id_valid;
  logic        id_ready;
  logic [2:0]  id_class;
  logic [3:0]  id_subclass;
  logic [31:0] id_imm;
  logic [3:0]  id_crs1;
  logic [3:0]  id_crs2;
  logic [3:0]  id_crs3;
  logic [3:0]  id_crd;

  // CPR read port
  logic [3:0]  cpr_rd_addr1;
  logic [3:0]  cpr_rd_addr2;
  logic [3:0]  cpr_rd_addr3;
  logic [31:0] cpr_rd_data1;
  logic [31:0] cpr_rd_data2;
  logic [31:0] cpr_rd_data3;

  // MALU issue and result
  logic        malu_ivalid;
  logic        malu_idone;
  logic [31:0] malu_rs1;
  logic [31:0] malu_rs2;
  logic [31:0] malu_rs3;
  logic [31:0] malu_imm;
  logic [2:0]  malu_class;
  logic [3:0]  malu_subclass;
  logic [3:0]  malu_cpr_rd_ben;
  logic [31:0] malu_cpr_rd_wdata;

  // CPR write port
  logic [3:0]  cpr_wen;
  logic [3:0]  cpr_waddr;
  logic [31:0] cpr_wdata;

  // Completion status
  logic        disp_done;
  logic        disp_fault;

  modport slave (
    input  id_valid, id_class, id_subclass, id_imm,
    input  id_crs1, id_crs2, id_crs3, id_crd,
    input  cpr_rd_data1, cpr_rd_data2, cpr_rd_data3,
    input  malu_idone, malu_cpr_rd_ben, malu_cpr_rd_wdata,
    output id_ready,
    output cpr_rd_addr1, cpr_rd_addr2, cpr_rd_addr3,
    output malu_ivalid, malu_rs1, malu_rs2, malu_rs3,
    output malu_imm, malu_class, malu_subclass,
    output cpr_wen, cpr_waddr, cpr_wdata,
    output disp_done, disp_fault
  );

  modport master (
    output id_valid, id_class, id_subclass, id_imm,
    output id_crs1, id_crs2, id_crs3, id_crd,
    output cpr_rd_data1, cpr_rd_data2, cpr_rd_data3,
    output malu_idone, malu_cpr_rd_ben, malu_cpr_rd_wdata,
    input  id_ready,
    input  cpr_rd_addr1, cpr_rd_addr2, cpr_rd_addr3,
    input  malu_ivalid, malu_rs1, malu_rs2, malu_rs3,
    input  malu_imm, malu_class, malu_subclass,
    input  cpr_wen, cpr_waddr, cpr_wdata,
    input  disp_done, disp_fault
  );
endinterface

// File: rtl/scarv_cop_malu_dispatch.sv
// Issue/writeback sequencer in front of the multi-precision ALU.
// Accepts one decoded instruction, latches its CPR operands for the whole
// execution, writes the byte-enabled result back and reports done or a
// timeout fault. Sequence is IDLE -> EXEC -> WB -> IDLE.
module scarv_cop_malu_dispatch #(
  parameter int TIMEOUT = 64
) (
  input  logic                        g_clk,
  input  logic                        g_reset,
  scarv_cop_malu_dispatch_if.slave    bus
);

  // Counter holds 0..TIMEOUT-1; TIMEOUT >= 2 keeps the width non-zero.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Operands and instruction fields, frozen for the whole of EXEC
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] rs3_q, rs3_d;
  logic [31:0] imm_q, imm_d;
  logic [2:0]  class_q, class_d;
  logic [3:0]  subclass_q, subclass_d;
  logic [3:0]  crd_q, crd_d;

  // Registered outputs
  logic        ivalid_q, ivalid_d;
  logic [3:0]  wen_q, wen_d;
  logic [3:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;

  // CPR reads are addressed straight from decode so data arrives in the accept cycle
  assign bus.cpr_rd_addr1 = bus.id_crs1;
  assign bus.cpr_rd_addr2 = bus.id_crs2;
  assign bus.cpr_rd_addr3 = bus.id_crs3;

  assign bus.id_ready      = (state_q == ST_IDLE);
  assign bus.malu_ivalid   = ivalid_q;
  assign bus.malu_rs1      = rs1_q;
  assign bus.malu_rs2      = rs2_q;
  assign bus.malu_rs3      = rs3_q;
  assign bus.malu_imm      = imm_q;
  assign bus.malu_class    = class_q;
  assign bus.malu_subclass = subclass_q;
  assign bus.cpr_wen       = wen_q;
  assign bus.cpr_waddr     = waddr_q;
  assign bus.cpr_wdata     = wdata_q;
  assign bus.disp_done     = done_q;
  assign bus.disp_fault    = fault_q;

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every bus output comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rs3_d      = rs3_q;
    imm_d      = imm_q;
    class_d    = class_q;
    subclass_d = subclass_q;
    crd_d      = crd_q;
    ivalid_d   = 1'b0;
    wen_d      = 4'b0000;
    waddr_d    = 4'h0;
    wdata_d    = 32'h0;
    done_d     = 1'b0;
    fault_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.id_valid) begin
          rs1_d      = bus.cpr_rd_data1;
          rs2_d      = bus.cpr_rd_data2;
          rs3_d      = bus.cpr_rd_data3;
          imm_d      = bus.id_imm;
          class_d    = bus.id_class;
          subclass_d = bus.id_subclass;
          crd_d      = bus.id_crd;
          cnt_d      = '0;
          ivalid_d   = 1'b1;
          state_d    = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // Completion takes priority, so idone on the terminal cycle still retires
        if (bus.malu_idone) begin
          wen_d   = bus.malu_cpr_rd_ben;
          waddr_d = crd_q;
          wdata_d = bus.malu_cpr_rd_wdata;
          done_d  = 1'b1;
          state_d = ST_WB;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          ivalid_d = 1'b1;
        end
      end

      ST_WB: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Single state/output register; reset abandons any in-flight instruction
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rs1_q      <= 32'h0;
      rs2_q      <= 32'h0;
      rs3_q      <= 32'h0;
      imm_q      <= 32'h0;
      class_q    <= 3'h0;
      subclass_q <= 4'h0;
      crd_q      <= 4'h0;
      ivalid_q   <= 1'b0;
      wen_q      <= 4'b0000;
      waddr_q    <= 4'h0;
      wdata_q    <= 32'h0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rs3_q      <= rs3_d;
      imm_q      <= imm_d;
      class_q    <= class_d;
      subclass_q <= subclass_d;
      crd_q      <= crd_d;
      ivalid_q   <= ivalid_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
    end
  end

endmodule

// File: tb/tb_scarv_cop_malu_dispatch.sv
// Bench for the MALU dispatcher: a CPR file model feeding the read port and
// absorbing writes, a shadow register file holding expected contents, a
// queue of expected completions popped when done/fault pulse, and a table
// of instructions with varied idone delays and byte enables.
module tb_scarv_cop_malu_dispatch;
  localparam int TIMEOUT = 64;

  logic g_clk   = 1'b0;
  logic g_reset = 1'b1;
  logic cpr_load = 1'b1;

  scarv_cop_malu_dispatch_if bus();

  scarv_cop_malu_dispatch #(.TIMEOUT(TIMEOUT)) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .bus     (bus)
  );

  always #5 g_clk = ~g_clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    if (i == 1) return 32'h11223344;
    return (32'(i) * 32'h01010101) ^ 32'h5A5AA5A5;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] ben);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (ben[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // CPR file: written only from the DUT's write port
  logic [31:0] cpr [16];
  always @(posedge g_clk) begin
    if (cpr_load) begin
      for (int i = 0; i < 16; i++) cpr[i] <= init_val(i);
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.cpr_wen[b]) cpr[bus.cpr_waddr][b*8 +: 8] <= bus.cpr_wdata[b*8 +: 8];
    end
  end
  assign bus.cpr_rd_data1 = cpr[bus.cpr_rd_addr1];
  assign bus.cpr_rd_data2 = cpr[bus.cpr_rd_addr2];
  assign bus.cpr_rd_data3 = cpr[bus.cpr_rd_addr3];

  // Expected register contents, updated from the expected results only
  logic [31:0] shadow [16];

  typedef struct {
    logic        fault;
    logic [3:0]  ben;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];
  exp_t sb_e;

  // Completion monitor: every done/fault must match the oldest expectation
  always @(negedge g_clk) begin
    if (!g_reset) begin
      if (bus.disp_done || bus.disp_fault) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: got done=%0b fault=%0b, expected no completion",
                   bus.disp_done, bus.disp_fault);
        end else begin
          sb_e = sbq.pop_front();
          check("sb_done",  32'(bus.disp_done),  32'(!sb_e.fault));
          check("sb_fault", 32'(bus.disp_fault), 32'(sb_e.fault));
          if (sb_e.fault) begin
            check("sb_fault_wen", 32'(bus.cpr_wen), 32'h0);
          end else begin
            check("sb_wen",   32'(bus.cpr_wen),   32'(sb_e.ben));
            check("sb_waddr", 32'(bus.cpr_waddr), 32'(sb_e.addr));
            check("sb_wdata", bus.cpr_wdata,      sb_e.data);
          end
        end
      end else begin
        check("wen_outside_wb", 32'(bus.cpr_wen), 32'h0);
      end
    end
  end

  typedef struct {
    logic [3:0]  crs1, crs2, crs3, crd;
    logic [2:0]  cls;
    logic [3:0]  sub;
    logic [31:0] imm;
    int          delay;      // EXEC cycle index carrying idone; >= TIMEOUT means never
    logic [3:0]  ben;
    logic [31:0] wdata;
    logic        exp_fault;
  } vec_t;

  // Entered and left at a negedge with the DUT in IDLE
  task automatic run_insn(input vec_t v);
    exp_t        e;
    logic [31:0] e1, e2, e3;
    bit          stable;
    check("id_ready_pre", 32'(bus.id_ready), 32'h1);
    bus.id_crs1 = v.crs1; bus.id_crs2 = v.crs2; bus.id_crs3 = v.crs3;
    bus.id_crd = v.crd; bus.id_class = v.cls; bus.id_subclass = v.sub;
    bus.id_imm = v.imm; bus.id_valid = 1'b1;
    e1 = shadow[v.crs1]; e2 = shadow[v.crs2]; e3 = shadow[v.crs3];
    @(negedge g_clk);
    bus.id_valid = 1'b0;
    e.fault = v.exp_fault; e.ben = v.ben; e.addr = v.crd; e.data = v.wdata;
    sbq.push_back(e);
    if (!v.exp_fault) shadow[v.crd] = merge(shadow[v.crd], v.wdata, v.ben);
    stable = 1'b1;
    for (int k = 0; k < TIMEOUT; k++) begin
      if (k > 0) @(negedge g_clk);
      if (k == 0) begin
        check("ivalid",   32'(bus.malu_ivalid),   32'h1);
        check("id_ready_exec", 32'(bus.id_ready), 32'h0);
        check("rs1",      bus.malu_rs1, e1);
        check("rs2",      bus.malu_rs2, e2);
        check("rs3",      bus.malu_rs3, e3);
        check("imm",      bus.malu_imm, v.imm);
        check("class",    32'(bus.malu_class),    32'(v.cls));
        check("subclass", 32'(bus.malu_subclass), 32'(v.sub));
      end else if (bus.malu_ivalid !== 1'b1 || bus.id_ready !== 1'b0 ||
                   bus.malu_rs1 !== e1 || bus.malu_rs2 !== e2 || bus.malu_rs3 !== e3 ||
                   bus.malu_imm !== v.imm) begin
        stable = 1'b0;
      end
      if (k == v.delay) begin
        bus.malu_idone = 1'b1;
        bus.malu_cpr_rd_ben = v.ben;
        bus.malu_cpr_rd_wdata = v.wdata;
        break;
      end
    end
    @(negedge g_clk);
    bus.malu_idone = 1'b0;
    bus.malu_cpr_rd_ben = 4'h0;
    bus.malu_cpr_rd_wdata = 32'h0;
    check("ops_stable", 32'(stable), 32'h1);
    check("ivalid_after", 32'(bus.malu_ivalid), 32'h0);
    if (v.exp_fault) begin
      check("fault_pulse", 32'(bus.disp_fault), 32'h1);
      check("id_ready_after_fault", 32'(bus.id_ready), 32'h1);
    end else begin
      check("done_latency", 32'(bus.disp_done), 32'h1);
      check("id_ready_wb", 32'(bus.id_ready), 32'h0);
      @(negedge g_clk);
      check("done_one_cycle", 32'(bus.disp_done), 32'h0);
      check("id_ready_post", 32'(bus.id_ready), 32'h1);
    end
  endtask

  vec_t vecs [8];

  initial begin
    //            crs1  crs2  crs3  crd   cls   sub   imm            delay       ben      wdata          flt
    vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd5, 3'd1, 4'h2, 32'h00000010, 0,          4'b1111, 32'hCAFEF00D, 1'b0};
    vecs[1] = '{4'd4, 4'd5, 4'd6, 4'd7, 3'd2, 4'h5, 32'hDEADBEEF, 9,          4'b0011, 32'h12345678, 1'b0};
    vecs[2] = '{4'd7, 4'd0, 4'd5, 4'd3, 3'd3, 4'h9, 32'h00000001, 2,          4'b0000, 32'hFFFFFFFF, 1'b0};
    vecs[3] = '{4'd8, 4'd9, 4'd10,4'd3, 3'd4, 4'hA, 32'h80000000, 1,          4'b1111, 32'h0BADBEEF, 1'b0};
    vecs[4] = '{4'd3, 4'd3, 4'd5, 4'd9, 3'd5, 4'hB, 32'h7FFFFFFF, 0,          4'b1100, 32'hA5A5A5A5, 1'b0};
    vecs[5] = '{4'd1, 4'd2, 4'd3, 4'd6, 3'd6, 4'hC, 32'h0000FFFF, TIMEOUT,    4'b1111, 32'h99999999, 1'b1};
    vecs[6] = '{4'd1, 4'd2, 4'd3, 4'd6, 3'd7, 4'hD, 32'hFFFF0000, TIMEOUT-1,  4'b1010, 32'h77665544, 1'b0};
    vecs[7] = '{4'd6, 4'd5, 4'd7, 4'd0, 3'd0, 4'hF, 32'h13579BDF, 4,          4'b0001, 32'h000000EE, 1'b0};

    bus.id_valid = 1'b0; bus.id_class = 3'h0; bus.id_subclass = 4'h0; bus.id_imm = 32'h0;
    bus.id_crs1 = 4'h0; bus.id_crs2 = 4'h0; bus.id_crs3 = 4'h0; bus.id_crd = 4'h0;
    bus.malu_idone = 1'b0; bus.malu_cpr_rd_ben = 4'h0; bus.malu_cpr_rd_wdata = 32'h0;
    for (int i = 0; i < 16; i++) shadow[i] = init_val(i);

    // Reset state
    repeat (3) @(negedge g_clk);
    check("rst_id_ready",   32'(bus.id_ready),    32'h1);
    check("rst_ivalid",     32'(bus.malu_ivalid), 32'h0);
    check("rst_wen",        32'(bus.cpr_wen),     32'h0);
    check("rst_done",       32'(bus.disp_done),   32'h0);
    check("rst_fault",      32'(bus.disp_fault),  32'h0);
    check("rst_rs1",        bus.malu_rs1,         32'h0);
    g_reset = 1'b0;
    cpr_load = 1'b0;
    @(negedge g_clk);
    check("idle_id_ready", 32'(bus.id_ready), 32'h1);

    // Table: single ops, partial/zero enables, back-to-back RAW, timeout and terminal idone
    for (int i = 0; i < 8; i++) run_insn(vecs[i]);

    // Reset in the middle of EXEC abandons the instruction
    bus.id_crs1 = 4'd2; bus.id_crs2 = 4'd3; bus.id_crs3 = 4'd4; bus.id_crd = 4'd11;
    bus.id_imm = 32'h55AA55AA; bus.id_valid = 1'b1;
    @(negedge g_clk);
    bus.id_valid = 1'b0;
    check("mid_ivalid", 32'(bus.malu_ivalid), 32'h1);
    @(negedge g_clk);
    g_reset = 1'b1;
    #1;
    check("mid_rst_ivalid",   32'(bus.malu_ivalid), 32'h0);
    check("mid_rst_id_ready", 32'(bus.id_ready),    32'h1);
    check("mid_rst_rs1",      bus.malu_rs1,         32'h0);
    @(negedge g_clk);
    g_reset = 1'b0;
    bus.malu_idone = 1'b1; bus.malu_cpr_rd_ben = 4'hF; bus.malu_cpr_rd_wdata = 32'hBAADF00D;
    repeat (2) @(negedge g_clk);
    check("stale_idone_done", 32'(bus.disp_done), 32'h0);
    check("stale_idone_wen",  32'(bus.cpr_wen),   32'h0);
    check("stale_id_ready",   32'(bus.id_ready),  32'h1);
    bus.malu_idone = 1'b0; bus.malu_cpr_rd_ben = 4'h0; bus.malu_cpr_rd_wdata = 32'h0;
    @(negedge g_clk);

    // Final CPR contents against expected, and no outstanding completions
    for (int i = 0; i < 16; i++) check($sformatf("cpr[%0d]", i), cpr[i], shadow[i]);
    check("sb_drained", 32'(sbq.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
